// File: rtl/trigger_pkg.sv
// Shared types and helpers for the multi-stage trigger sequencer.
package trigger_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StTriggered
    } trig_state_e;

    localparam logic MT_LEVEL = 1'b0;
    localparam logic MT_EDGE  = 1'b1;

    // Effective stage count: 0 behaves as 1, anything above max is capped.
    function automatic int unsigned clamp_stages(input int unsigned num,
                                                 input int unsigned max_stages);
        if (num == 0) begin
            return 1;
        end
        if (num > max_stages) begin
            return max_stages;
        end
        return num;
    endfunction

endpackage

// File: rtl/trig_stage_match.sv
// Combinational match of one sample against one stage's mask/type/level config.
module trig_stage_match
    import trigger_pkg::*;
#(
    parameter int unsigned Size = 32
) (
    input  logic [Size-1:0] sample_i,
    input  logic [Size-1:0] prev_i,
    input  logic            prev_ok_i,
    input  logic [Size-1:0] mask_i,
    input  logic [Size-1:0] type_i,
    input  logic [Size-1:0] level_i,
    output logic            hit_o
);

    logic [Size-1:0] bit_ok;

    always_comb begin
        bit_ok = '0;
        for (int b = 0; b < Size; b++) begin
            if (!mask_i[b]) begin
                bit_ok[b] = 1'b1;
            end else if (type_i[b] == MT_EDGE) begin
                bit_ok[b] = prev_ok_i && (prev_i[b] != sample_i[b]) && (sample_i[b] == level_i[b]);
            end else begin
                bit_ok[b] = (sample_i[b] == level_i[b]);
            end
        end
    end

    assign hit_o = &bit_ok;

endmodule

// File: rtl/trigger_seq.sv
// Multi-stage trigger sequencer: steps through configurable match stages and reports
// the trigger moment and the valid-sample index of the triggering sample.
module trigger_seq
    import trigger_pkg::*;
#(
    parameter int unsigned Size   = 32,
    parameter int unsigned Stages = 8,
    parameter int unsigned CntW   = 16,
    parameter int unsigned SaddrW = 24,
    localparam int unsigned StageW = (Stages > 1) ? $clog2(Stages) : 1,
    localparam int unsigned NumW   = $clog2(Stages) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [Size-1:0]        sample_i,
    input  logic                   sample_valid_i,
    input  logic                   arm_i,
    input  logic                   abort_i,
    input  logic [NumW-1:0]        num_stages_i,
    input  logic [Stages*Size-1:0] stage_mask_i,
    input  logic [Stages*Size-1:0] stage_type_i,
    input  logic [Stages*Size-1:0] stage_level_i,
    input  logic [Stages*CntW-1:0] stage_count_i,
    output logic                   armed_o,
    output logic                   triggered_o,
    output logic                   trig_pulse_o,
    output logic [StageW-1:0]      cur_stage_o,
    output logic [SaddrW-1:0]      trigger_pos_o
);

    trig_state_e       state_q;
    logic [StageW-1:0] cur_stage_q;
    logic [CntW-1:0]   occ_q;
    logic [SaddrW-1:0] idx_q;
    logic [Size-1:0]   prev_q;
    logic              prev_ok_q;
    logic              triggered_q;
    logic              trig_pulse_q;
    logic [SaddrW-1:0] trigger_pos_q;

    logic [Size-1:0] sel_mask, sel_type, sel_level;
    logic [CntW-1:0] sel_count;
    logic            hit;
    logic [CntW:0]   occ_inc, occ_req;
    logic            reached, last_stage;
    logic [SaddrW-1:0] idx_d;
    int unsigned     eff_stages;

    // Only the current stage's config is routed to the single matcher.
    assign sel_mask  = stage_mask_i[int'(cur_stage_q)*Size +: Size];
    assign sel_type  = stage_type_i[int'(cur_stage_q)*Size +: Size];
    assign sel_level = stage_level_i[int'(cur_stage_q)*Size +: Size];
    assign sel_count = stage_count_i[int'(cur_stage_q)*CntW +: CntW];

    trig_stage_match #(
        .Size (Size)
    ) u_match (
        .sample_i  (sample_i),
        .prev_i    (prev_q),
        .prev_ok_i (prev_ok_q),
        .mask_i    (sel_mask),
        .type_i    (sel_type),
        .level_i   (sel_level),
        .hit_o     (hit)
    );

    always_comb begin
        occ_inc    = {1'b0, occ_q} + (CntW + 1)'(1);
        occ_req    = (sel_count == '0) ? (CntW + 1)'(1) : {1'b0, sel_count};
        reached    = (occ_inc >= occ_req);
        eff_stages = clamp_stages(32'(num_stages_i), Stages);
        last_stage = (32'(cur_stage_q) == eff_stages - 1);
        idx_d      = (&idx_q) ? idx_q : idx_q + SaddrW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            cur_stage_q   <= '0;
            occ_q         <= '0;
            idx_q         <= '0;
            prev_q        <= '0;
            prev_ok_q     <= 1'b0;
            triggered_q   <= 1'b0;
            trig_pulse_q  <= 1'b0;
            trigger_pos_q <= '0;
        end else begin
            trig_pulse_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (arm_i && !abort_i) begin
                        state_q     <= StArmed;
                        cur_stage_q <= '0;
                        occ_q       <= '0;
                        idx_q       <= '0;
                        prev_ok_q   <= 1'b0;
                        triggered_q <= 1'b0;
                    end
                end
                StArmed: begin
                    if (abort_i) begin
                        state_q     <= StIdle;
                        cur_stage_q <= '0;
                        occ_q       <= '0;
                    end else if (sample_valid_i) begin
                        prev_q    <= sample_i;
                        prev_ok_q <= 1'b1;
                        idx_q     <= idx_d;
                        if (hit) begin
                            if (reached) begin
                                occ_q <= '0;
                                if (last_stage) begin
                                    state_q       <= StTriggered;
                                    triggered_q   <= 1'b1;
                                    trig_pulse_q  <= 1'b1;
                                    trigger_pos_q <= idx_q;
                                end else begin
                                    cur_stage_q <= cur_stage_q + StageW'(1);
                                end
                            end else begin
                                occ_q <= occ_inc[CntW-1:0];
                            end
                        end
                    end
                end
                StTriggered: begin
                    if (abort_i) begin
                        state_q     <= StIdle;
                        triggered_q <= 1'b0;
                        cur_stage_q <= '0;
                    end else if (arm_i) begin
                        state_q     <= StArmed;
                        cur_stage_q <= '0;
                        occ_q       <= '0;
                        idx_q       <= '0;
                        prev_ok_q   <= 1'b0;
                        triggered_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign armed_o       = (state_q == StArmed);
    assign triggered_o   = triggered_q;
    assign trig_pulse_o  = trig_pulse_q;
    assign cur_stage_o   = cur_stage_q;
    assign trigger_pos_o = trigger_pos_q;

endmodule

// File: tb/tb_trigger_seq.sv
// Directed bench for trigger_seq with hand-computed expectations.
module tb_trigger_seq;

    localparam int unsigned Size   = 32;
    localparam int unsigned Stages = 8;
    localparam int unsigned CntW   = 16;
    localparam int unsigned SaddrW = 24;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [Size-1:0]        sample = '0;
    logic                   sample_valid = 1'b0;
    logic                   arm = 1'b0;
    logic                   abort = 1'b0;
    logic [3:0]             num_stages = '0;
    logic [Stages*Size-1:0] stage_mask = '0;
    logic [Stages*Size-1:0] stage_type = '0;
    logic [Stages*Size-1:0] stage_level = '0;
    logic [Stages*CntW-1:0] stage_count = '0;
    logic                   armed, triggered, trig_pulse;
    logic [2:0]             cur_stage;
    logic [SaddrW-1:0]      trigger_pos;

    int total = 0;
    int bad   = 0;

    trigger_seq #(
        .Size   (Size),
        .Stages (Stages),
        .CntW   (CntW),
        .SaddrW (SaddrW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sample_i       (sample),
        .sample_valid_i (sample_valid),
        .arm_i          (arm),
        .abort_i        (abort),
        .num_stages_i   (num_stages),
        .stage_mask_i   (stage_mask),
        .stage_type_i   (stage_type),
        .stage_level_i  (stage_level),
        .stage_count_i  (stage_count),
        .armed_o        (armed),
        .triggered_o    (triggered),
        .trig_pulse_o   (trig_pulse),
        .cur_stage_o    (cur_stage),
        .trigger_pos_o  (trigger_pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [Size-1:0] s);
        sample       = s;
        sample_valid = 1'b1;
        cycle();
        sample_valid = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
    endtask

    task automatic set_stage(input int i, input logic [Size-1:0] m, input logic [Size-1:0] t,
                             input logic [Size-1:0] l, input logic [CntW-1:0] c);
        stage_mask[i*Size +: Size]  = m;
        stage_type[i*Size +: Size]  = t;
        stage_level[i*Size +: Size] = l;
        stage_count[i*CntW +: CntW] = c;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_armed", 32'(armed), 0);
        chk("rst_trig", 32'(triggered), 0);
        chk("rst_pulse", 32'(trig_pulse), 0);
        chk("rst_stage", 32'(cur_stage), 0);
        chk("rst_pos", 32'(trigger_pos), 0);
        rst = 1'b0;
        cycle();

        // 1: all masks zero, single stage -> first valid sample triggers
        num_stages = 4'd1;
        do_arm();
        chk("t1_armed", 32'(armed), 1);
        send(32'h123);
        chk("t1_trig", 32'(triggered), 1);
        chk("t1_pulse", 32'(trig_pulse), 1);
        chk("t1_pos", 32'(trigger_pos), 0);
        cycle();
        chk("t1_pulse_off", 32'(trig_pulse), 0);
        chk("t1_trig_held", 32'(triggered), 1);
        chk("t1_armed_off", 32'(armed), 0);
        do_abort();
        chk("t1_abort_trig", 32'(triggered), 0);

        // 2: level on bit0, count 3; non-hit samples keep the counter
        set_stage(0, 32'h1, 32'h0, 32'h1, 16'd3);
        do_arm();
        send(32'h1);
        send(32'h0);
        send(32'h1);
        chk("t2_not_yet", 32'(triggered), 0);
        send(32'h1);
        chk("t2_trig", 32'(triggered), 1);
        chk("t2_pulse", 32'(trig_pulse), 1);
        chk("t2_pos", 32'(trigger_pos), 3);
        // Re-arm from triggered
        do_arm();
        chk("t2_rearm_trig", 32'(triggered), 0);
        chk("t2_rearm_armed", 32'(armed), 1);
        chk("t2_rearm_stage", 32'(cur_stage), 0);
        do_abort();

        // 3: rising edge on bit4; first sample after arm cannot be an edge
        set_stage(0, 32'h10, 32'h10, 32'h10, 16'd1);
        do_arm();
        send(32'h10);
        chk("t3_first_no_edge", 32'(triggered), 0);
        send(32'h00);
        chk("t3_fall_no_trig", 32'(triggered), 0);
        send(32'h10);
        chk("t3_trig", 32'(triggered), 1);
        chk("t3_pos", 32'(trigger_pos), 2);
        do_abort();

        // 4: three stages: level 0xA, falling bit0, level 0x5 x2
        num_stages = 4'd3;
        set_stage(0, 32'hF, 32'h0, 32'hA, 16'd1);
        set_stage(1, 32'h1, 32'h1, 32'h0, 16'd1);
        set_stage(2, 32'hF, 32'h0, 32'h5, 16'd2);
        do_arm();
        send(32'h3);
        chk("t4_s0_hold", 32'(cur_stage), 0);
        send(32'hA);
        chk("t4_to_s1", 32'(cur_stage), 1);
        send(32'h1);
        chk("t4_rise_ignored", 32'(cur_stage), 1);
        send(32'h0);
        chk("t4_to_s2", 32'(cur_stage), 2);
        send(32'h5);
        send(32'h7);
        sample = 32'h5;
        cycle();
        chk("t4_invalid_ignored", 32'(triggered), 0);
        send(32'h5);
        chk("t4_trig", 32'(triggered), 1);
        chk("t4_pos", 32'(trigger_pos), 6);
        do_abort();
        // num_stages=0 behaves as 1
        num_stages = 4'd0;
        do_arm();
        send(32'hA);
        chk("t4_zero_trig", 32'(triggered), 1);
        chk("t4_zero_pos", 32'(trigger_pos), 0);
        do_abort();

        // 5: abort beats arm and a matching sample in the same cycle
        num_stages = 4'd1;
        do_arm();
        send(32'h3);
        abort        = 1'b1;
        arm          = 1'b1;
        sample       = 32'hA;
        sample_valid = 1'b1;
        cycle();
        abort        = 1'b0;
        arm          = 1'b0;
        sample_valid = 1'b0;
        chk("t5_armed", 32'(armed), 0);
        chk("t5_trig", 32'(triggered), 0);
        chk("t5_pulse", 32'(trig_pulse), 0);
        cycle();
        chk("t5_pulse_later", 32'(trig_pulse), 0);

        // 6: asynchronous reset mid-sequence
        num_stages = 4'd3;
        do_arm();
        send(32'hA);
        send(32'h1);
        send(32'h0);
        chk("t6_stage2", 32'(cur_stage), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_armed", 32'(armed), 0);
        chk("t6_rst_stage", 32'(cur_stage), 0);
        chk("t6_rst_trig", 32'(triggered), 0);
        rst = 1'b0;
        cycle();
        send(32'h5);
        send(32'h5);
        chk("t6_idle_armed", 32'(armed), 0);
        chk("t6_idle_trig", 32'(triggered), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trigger_seq.md
Name: trigger_seq

Overview:
Parametrised multi-stage trigger sequencer for the logic-analyser capture path. It replaces the fixed 8-level mask/type/level trigger with N configurable stages. Each stage has level/edge matching, an occurrence count and a programmable active-stage depth. It sits between the sampled input stream and the capture controller, and reports the trigger moment and the trigger sample index for pre/post-trigger buffering.

Parameters:
size, 32, sample width in bits
stages, 8, number of sequencer stages (1..16)
cnt_w, 16, occurrence counter width per stage
saddr_w, 24, sample index / trigger position width

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high; clears all state
sample  in  size  current sample word
sample_valid  in  1  sample qualifies this cycle
arm  in  1  pulse: start sequence from stage 0
abort  in  1  pulse: return to idle
num_stages  in  $clog2(stages)+1  active stage count
stage_mask  in  stages*size  per-stage bit mask, stage i at [i*size +: size]
stage_type  in  stages*size  per bit: 0 = level, 1 = edge
stage_level  in  stages*size  level value, or edge polarity (1 = rising, 0 = falling)
stage_count  in  stages*cnt_w  required matches per stage
armed  out  1  sequencer waiting for trigger
triggered  out  1  final stage satisfied; held until arm/abort/reset
trig_pulse  out  1  one-cycle pulse on trigger
cur_stage  out  $clog2(stages)  stage currently evaluated
trigger_pos  out  saddr_w  valid-sample index of the triggering sample

Behaviour:
- Reset values: armed=0, triggered=0, trig_pulse=0, cur_stage=0, trigger_pos=0, prev sample=0, prev_ok=0, counters=0; state IDLE.
- States:
  - IDLE: arm -> ARMED. Entering ARMED clears cur_stage, occurrence counter, sample index, prev_ok and triggered.
  - ARMED: evaluates stage matches on each sample_valid.
  - TRIGGERED: terminal. arm -> ARMED (re-arm); abort -> IDLE.
- Abort has priority over arm and over a match in the same cycle. Arm while ARMED is ignored.
- Bit match, only for bits with mask=1:
  - level: sample[b]==level[b].
  - edge: prev_ok & (prev[b]!=sample[b]) & (sample[b]==level[b]).
- Stage hit = AND over masked bits. An all-zero mask hits on every valid sample.
- prev and prev_ok update on each sample_valid in ARMED. The first valid sample after arm cannot satisfy an edge bit.
- Occurrence count: stage_count=0 is treated as 1.
  - On a hit, count+1 is compared to the required count. If reached: counter clears and cur_stage advances. Otherwise the counter increments.
  - Non-hit valid samples do not clear the counter.
- Final stage is index eff-1, where eff = num_stages clamped to [1, stages]. Reaching the count on the final stage goes to TRIGGERED.
- Trigger timing: registered. triggered and trig_pulse go high in the cycle after the clock edge that sampled the final hit (1-cycle latency). trig_pulse is high for exactly one cycle.
- Sample index: counts valid samples from 0 after arm and saturates at all-ones. trigger_pos latches the index of the triggering sample.
- armed=1 only in ARMED.
- Config inputs are sampled live and must be static while armed; changing them while armed is undefined.
- Asserting reset in any state returns to IDLE asynchronously.

Decomposition:
- Shared package trigger_pkg holds:
  - state encoding (IDLE, ARMED, TRIGGERED);
  - match-type constants (MT_LEVEL=0, MT_EDGE=1);
  - helper function clamping num_stages.
- One sub-module, trig_stage_match: combinational; inputs sample, prev, prev_ok, mask, type, level; output hit.
- One instance is muxed by cur_stage. No per-stage replication is required.

Test Plan:
1. All masks 0, num_stages=1, arm, then valid samples -> trig_pulse one cycle after the first valid sample; trigger_pos=0.
2. Stage0 level mask=0x1, level=0x1, count=3; inputs 1,0,1,1 -> trigger on the 4th valid sample; trigger_pos=3.
3. Stage0 rising edge on bit 4; first sample after arm already 0x10 -> no trigger. Then 0x00 followed by 0x10 -> trigger; trigger_pos = index of the 0x10 sample.
4. num_stages=3: stage0 level 0xA, stage1 falling edge on bit 0, stage2 level 0x5 count 2 -> cur_stage steps 0→1→2, trigger after the second 0x5. num_stages=0 behaves as 1.
5. Abort and arm asserted in the same cycle while ARMED -> IDLE, armed=0, no trig_pulse. Arm in TRIGGERED clears triggered and restarts at stage 0.
6. Reset asserted mid-sequence (cur_stage=2) -> all outputs 0 immediately, without waiting for clk. Idle after release.
